// File: rtl/cr_huf_comp_st_sc_sched_if.sv
// Requester/st_sc bundle for the symbol-compress scheduler. Eob fields use the
// 2-bit pipe encoding: 0=MIDDLE, 1=FINAL, 2=PASS, 3=ABORT.
interface cr_huf_comp_st_sc_sched_if #(
  parameter int MAX_SYMBOL_TABLE_DEPTH = 584,
  parameter int SEQID_WIDTH            = 8
);
  localparam int PTR_W = $clog2(MAX_SYMBOL_TABLE_DEPTH + 1);

  logic [1:0]                   req_vld;
  logic [1:0][PTR_W-1:0]        req_wr_ptr;
  logic [1:0][SEQID_WIDTH-1:0]  req_seq_id;
  logic [1:0][1:0]              req_eob;
  logic [1:0]                   req_build_error;
  logic [1:0]                   sc_is_eob;
  logic [1:0]                   req_done;
  logic                         sc_sel;
  logic [PTR_W-1:0]             sc_wr_ptr;
  logic [SEQID_WIDTH-1:0]       sc_seq_id;
  logic [1:0]                   sc_eob;
  logic                         sc_build_error;
  logic [1:0]                   sc_hw_eob;
  logic                         sched_busy;
  logic                         sched_timeout;

  modport master (
    output req_vld, req_wr_ptr, req_seq_id, req_eob, req_build_error, sc_is_eob,
    input  req_done, sc_sel, sc_wr_ptr, sc_seq_id, sc_eob, sc_build_error,
           sc_hw_eob, sched_busy, sched_timeout
  );

  modport slave (
    input  req_vld, req_wr_ptr, req_seq_id, req_eob, req_build_error, sc_is_eob,
    output req_done, sc_sel, sc_wr_ptr, sc_seq_id, sc_eob, sc_build_error,
           sc_hw_eob, sched_busy, sched_timeout
  );
endinterface

// File: rtl/cr_huf_comp_st_sc_sched.sv
// Round-robin scheduler of two symbol-table builders onto one st_sc engine.
// Optional RUN watchdog enabled by defining CR_HUF_COMP_ST_SC_SCHED_TIMEOUT_EN.
module cr_huf_comp_st_sc_sched #(
  parameter int MAX_SYMBOL_TABLE_DEPTH = 584,
  parameter int TIMEOUT_CYCLES         = 4096,
  parameter int SEQID_WIDTH            = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  cr_huf_comp_st_sc_sched_if.slave     sched_if
);
  localparam int PTR_W = $clog2(MAX_SYMBOL_TABLE_DEPTH + 1);

  typedef enum logic [1:0] {
    EOB_MIDDLE = 2'd0,
    EOB_FINAL  = 2'd1,
    EOB_PASS   = 2'd2,
    EOB_ABORT  = 2'd3
  } e_pipe_eob;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e                 state_q;
  logic                   last_gnt_q;
  logic                   sel_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [SEQID_WIDTH-1:0] seq_id_q;
  e_pipe_eob              eob_q;
  logic                   build_error_q;
  e_pipe_eob              hw_eob_q;
  logic [1:0]             done_q;
  logic                   busy_q;

  logic [1:0] elig;
  logic       gnt_d;
  logic       final_beat;
  logic       timeout_hit;

  // A MIDDLE-eob table is not a complete frame and is never scheduled.
  assign elig[0] = sched_if.req_vld[0] && (sched_if.req_eob[0] != EOB_MIDDLE);
  assign elig[1] = sched_if.req_vld[1] && (sched_if.req_eob[1] != EOB_MIDDLE);

  assign final_beat = (sched_if.sc_is_eob != EOB_MIDDLE);

  always_comb begin
    // NOTE: default assignment first so every path drives gnt_d; no latch is inferred.
    gnt_d = 1'b0;
    if (elig == 2'b11) gnt_d = ~last_gnt_q;
    else if (elig[1])  gnt_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_gnt_q    <= 1'b1;
      sel_q         <= 1'b0;
      wr_ptr_q      <= '0;
      seq_id_q      <= '0;
      eob_q         <= EOB_MIDDLE;
      build_error_q <= 1'b0;
      hw_eob_q      <= EOB_MIDDLE;
      done_q        <= '0;
      busy_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q   <= '0;
      hw_eob_q <= EOB_MIDDLE;
      unique case (state_q)
        ST_IDLE: begin
          if (|elig) begin
            state_q       <= ST_LOAD;
            busy_q        <= 1'b1;
            sel_q         <= gnt_d;
            wr_ptr_q      <= sched_if.req_wr_ptr[gnt_d];
            seq_id_q      <= sched_if.req_seq_id[gnt_d];
            eob_q         <= e_pipe_eob'(sched_if.req_eob[gnt_d]);
            build_error_q <= sched_if.req_build_error[gnt_d];
          end
        end
        ST_LOAD: begin
          state_q  <= ST_KICK;
          hw_eob_q <= eob_q;
        end
        ST_KICK: state_q <= ST_RUN;
        ST_RUN: begin
          if (final_beat || timeout_hit) begin
            state_q        <= ST_DONE;
            done_q[sel_q]  <= 1'b1;
            last_gnt_q     <= sel_q;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CR_HUF_COMP_ST_SC_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  // Count of completed RUN cycles; the last allowed RUN cycle forces the exit.
  assign timeout_hit = (state_q == ST_RUN) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit && !final_beat;
      if (state_q == ST_KICK) begin
        cnt_q <= '0;
      end else if ((state_q == ST_RUN) && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign sched_if.sched_timeout = timeout_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit            = 1'b0;
  assign sched_if.sched_timeout = 1'b0;
`endif

  assign sched_if.req_done       = done_q;
  assign sched_if.sc_sel         = sel_q;
  assign sched_if.sc_wr_ptr      = wr_ptr_q;
  assign sched_if.sc_seq_id      = seq_id_q;
  assign sched_if.sc_eob         = eob_q;
  assign sched_if.sc_build_error = build_error_q;
  assign sched_if.sc_hw_eob      = hw_eob_q;
  assign sched_if.sched_busy     = busy_q;

endmodule

// File: tb/tb_cr_huf_comp_st_sc_sched.sv
// Directed scoreboard bench for cr_huf_comp_st_sc_sched; the bench plays both
// requesters and the st_sc final-beat timing (ceil((wr_ptr+1)/4)+4 after start).
module tb_cr_huf_comp_st_sc_sched;
  localparam int D     = 584;
  localparam int SEQ_W = 8;
  localparam int PTR_W = $clog2(D + 1);

  localparam logic [1:0] EOB_MIDDLE = 2'd0;
  localparam logic [1:0] EOB_FINAL  = 2'd1;
  localparam logic [1:0] EOB_PASS   = 2'd2;

  typedef struct {
    logic             owner;
    logic [PTR_W-1:0] wr_ptr;
    logic [SEQ_W-1:0] seq_id;
    logic [1:0]       eob;
    logic             berr;
  } exp_t;

  exp_t sb_q[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass   = 0;
  int   n_checks = 0;
  logic tb_last_gnt;

  always #5 clk = ~clk;

  cr_huf_comp_st_sc_sched_if #(.MAX_SYMBOL_TABLE_DEPTH(D), .SEQID_WIDTH(SEQ_W)) bus ();

  cr_huf_comp_st_sc_sched #(
    .MAX_SYMBOL_TABLE_DEPTH(D),
    .TIMEOUT_CYCLES        (16),
    .SEQID_WIDTH           (SEQ_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sched_if(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},   32'(bus.req_done), 32'd0);
    check({tag, "_sel"},    32'(bus.sc_sel), 32'd0);
    check({tag, "_ptr"},    32'(bus.sc_wr_ptr), 32'd0);
    check({tag, "_seq"},    32'(bus.sc_seq_id), 32'd0);
    check({tag, "_berr"},   32'(bus.sc_build_error), 32'd0);
    check({tag, "_busy"},   32'(bus.sched_busy), 32'd0);
    check({tag, "_tmo"},    32'(bus.sched_timeout), 32'd0);
    check({tag, "_eob"},    32'(bus.sc_eob), 32'(EOB_MIDDLE));
    check({tag, "_hw_eob"}, 32'(bus.sc_hw_eob), 32'(EOB_MIDDLE));
  endtask

  function automatic logic model_gnt();
    logic e0, e1;
    e0 = bus.req_vld[0] && (bus.req_eob[0] != EOB_MIDDLE);
    e1 = bus.req_vld[1] && (bus.req_eob[1] != EOB_MIDDLE);
    if (e0 && e1) return ~tb_last_gnt;
    return e1;
  endfunction

  // Called at the negedge just before the granting posedge; ends at the IDLE negedge.
  task automatic expect_run(input bit stale, input bit perturb, input int extra);
    exp_t       e;
    exp_t       got;
    int         len;
    int         waited;
    logic [1:0] mask;
    e.owner  = model_gnt();
    e.wr_ptr = bus.req_wr_ptr[e.owner];
    e.seq_id = bus.req_seq_id[e.owner];
    e.eob    = bus.req_eob[e.owner];
    e.berr   = bus.req_build_error[e.owner];
    sb_q.push_back(e);
    len = (int'(e.wr_ptr) + 4) / 4 + 4;

    @(negedge clk);
    check("load_busy", 32'(bus.sched_busy), 32'd1);
    check("load_sel", 32'(bus.sc_sel), 32'(e.owner));
    check("load_ptr", 32'(bus.sc_wr_ptr), 32'(e.wr_ptr));
    check("load_seq", 32'(bus.sc_seq_id), 32'(e.seq_id));
    check("load_eob", 32'(bus.sc_eob), 32'(e.eob));
    check("load_berr", 32'(bus.sc_build_error), 32'(e.berr));
    check("load_hw_eob", 32'(bus.sc_hw_eob), 32'(EOB_MIDDLE));
    if (stale) bus.sc_is_eob = EOB_FINAL;

    @(negedge clk);
    bus.sc_is_eob = EOB_MIDDLE;
    check("kick_hw_eob", 32'(bus.sc_hw_eob), 32'(e.eob));

    for (int i = 1; i < len + extra; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("run_hw_eob", 32'(bus.sc_hw_eob), 32'(EOB_MIDDLE));
        if (perturb) begin
          bus.req_vld                = 2'b00;
          bus.req_wr_ptr[e.owner]    = ~e.wr_ptr;
        end
      end
      check("run_no_done", 32'(bus.req_done), 32'd0);
      check("run_no_tmo", 32'(bus.sched_timeout), 32'd0);
    end

    @(negedge clk);
    bus.sc_is_eob = e.eob;
    waited = 0;
    do begin
      @(negedge clk);
      bus.sc_is_eob = EOB_MIDDLE;
      waited++;
    end while ((bus.req_done == 2'b00) && (waited < 4));
    check("done_latency", 32'(waited), 32'd1);
    got  = sb_q.pop_front();
    mask = 2'b01 << got.owner;
    check("done_mask", 32'(bus.req_done), 32'(mask));
    check("done_ptr_stable", 32'(bus.sc_wr_ptr), 32'(got.wr_ptr));
    check("done_busy", 32'(bus.sched_busy), 32'd1);
    tb_last_gnt = got.owner;

    @(negedge clk);
    check("idle_done_clear", 32'(bus.req_done), 32'd0);
    check("idle_busy", 32'(bus.sched_busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.req_vld         = 2'b00;
    bus.req_wr_ptr      = '0;
    bus.req_seq_id      = '0;
    bus.req_eob         = {EOB_MIDDLE, EOB_MIDDLE};
    bus.req_build_error = 2'b00;
    bus.sc_is_eob       = EOB_MIDDLE;
    tb_last_gnt         = 1'b1;
    rst_n               = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single requester, 8 symbols.
    bus.req_wr_ptr[0] = PTR_W'(7);
    bus.req_seq_id[0] = 8'h11;
    bus.req_eob[0]    = EOB_FINAL;
    bus.req_vld       = 2'b01;
    expect_run(1'b0, 1'b0, 0);
    bus.req_vld = 2'b00;

    // Both held ready: strict alternation, single-symbol and full-buffer tables.
    bus.req_wr_ptr[0]      = PTR_W'(0);
    bus.req_seq_id[0]      = 8'h5a;
    bus.req_wr_ptr[1]      = PTR_W'(D - 1);
    bus.req_seq_id[1]      = 8'h22;
    bus.req_eob[1]         = EOB_PASS;
    bus.req_build_error[1] = 1'b1;
    bus.req_vld            = 2'b11;
    repeat (4) expect_run(1'b0, 1'b0, 0);
    bus.req_vld = 2'b00;

    // MIDDLE-eob request is never granted until its eob changes.
    bus.req_eob[1]    = EOB_MIDDLE;
    bus.req_wr_ptr[1] = PTR_W'(12);
    bus.req_vld       = 2'b10;
    repeat (5) begin
      @(negedge clk);
      check("middle_idle_busy", 32'(bus.sched_busy), 32'd0);
      check("middle_idle_hw_eob", 32'(bus.sc_hw_eob), 32'(EOB_MIDDLE));
    end
    bus.req_eob[1] = EOB_FINAL;
    expect_run(1'b0, 1'b0, 0);
    bus.req_vld = 2'b00;

    // Stale beat in LOAD, requester drops and rewrites fields mid-run.
    bus.req_wr_ptr[0]      = PTR_W'(20);
    bus.req_seq_id[0]      = 8'h33;
    bus.req_eob[0]         = EOB_PASS;
    bus.req_build_error[0] = 1'b1;
    bus.req_vld            = 2'b01;
    expect_run(1'b1, 1'b1, 0);

    // Reset in RUN abandons the run; arbitration restarts with req 0.
    bus.req_wr_ptr[1] = PTR_W'(40);
    bus.req_vld       = 2'b10;
    repeat (4) @(negedge clk);
    check("abort_busy_run", 32'(bus.sched_busy), 32'd1);
    rst_n         = 1'b0;
    bus.sc_is_eob = EOB_FINAL;
    @(negedge clk);
    check_reset_outputs("abort");
    rst_n         = 1'b1;
    bus.sc_is_eob = EOB_MIDDLE;
    tb_last_gnt   = 1'b1;
    bus.req_eob   = {EOB_FINAL, EOB_FINAL};
    bus.req_vld   = 2'b11;
    check("abort_model_pick", 32'(model_gnt()), 32'd0);
    expect_run(1'b0, 1'b0, 0);
    bus.req_vld = 2'b00;

    // Engine never finishes on its own.
    bus.req_wr_ptr[0] = PTR_W'(3);
    bus.req_eob[0]    = EOB_FINAL;
    bus.req_vld       = 2'b01;
`ifdef CR_HUF_COMP_ST_SC_SCHED_TIMEOUT_EN
    @(negedge clk);
    check("tmo_load_busy", 32'(bus.sched_busy), 32'd1);
    @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("tmo_early", 32'(bus.sched_timeout), 32'd0);
      check("tmo_no_done", 32'(bus.req_done), 32'd0);
    end
    @(negedge clk);
    bus.req_vld = 2'b00;
    check("tmo_pulse", 32'(bus.sched_timeout), 32'd1);
    check("tmo_done", 32'(bus.req_done), 32'd1);
    @(negedge clk);
    check("tmo_pulse_clear", 32'(bus.sched_timeout), 32'd0);
    check("tmo_idle_busy", 32'(bus.sched_busy), 32'd0);
    tb_last_gnt = 1'b0;
`else
    expect_run(1'b0, 1'b0, 40);
    bus.req_vld = 2'b00;
`endif

    @(negedge clk);
    check("final_idle_busy", 32'(bus.sched_busy), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
